ub_stream_reader: RTL and testbench
===================================

UB_STREAM_READER -- requirements
Module: ub_stream_reader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 128, the unified-buffer row width in bits (16 lanes x 8 bits).
REQ-002 SHALL have parameter DEPTH, default 256, the unified-buffer entry count; ADDR_WIDTH = clog2(DEPTH) = 8.
REQ-003 SHALL have port clk  input  1  single clock; all flops posedge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  one-cycle request to stream a block of rows.
REQ-006 SHALL have port base_addr  input  ADDR_WIDTH  first row address, sampled with start.
REQ-007 SHALL have port length  input  ADDR_WIDTH+1  row count (0..DEPTH), sampled with start.
REQ-008 SHALL have port busy  output  1  transfer in progress.
REQ-009 SHALL have port done  output  1  one-cycle completion pulse.
REQ-010 SHALL have port bram_enb  output  1  buffer read enable.
REQ-011 SHALL have port bram_addrb  output  ADDR_WIDTH  buffer read address.
REQ-012 SHALL have port bram_doutb  input  DATA_WIDTH  buffer read data; valid by the negedge of the cycle bram_enb is high.
REQ-013 SHALL have port m_valid  output  1  stream beat valid.
REQ-014 SHALL have port m_ready  input  1  downstream (systolic array feeder) accepts beat.
REQ-015 SHALL have port m_data  output  DATA_WIDTH  stream beat payload.
REQ-016 SHALL have port m_last  output  1  marks the final beat of the block.

Function
REQ-017 SHALL implement FSM IDLE -> RUN -> DONE -> IDLE; start sampled only in IDLE; start in RUN/DONE ignored.
REQ-018 SHALL, on start with length=0, go IDLE -> DONE directly: no bram_enb, no beats, done pulses next cycle.
REQ-019 SHALL, on start with length>0, register base_addr/length; bram_enb first high the cycle after the start edge.
REQ-020 SHALL issue read k (k=0..length-1) at address (base_addr+k) mod DEPTH; wrap 255 -> 0 is legal.
REQ-021 SHALL capture bram_doutb into a 2-entry output FIFO at the posedge ending the bram_enb cycle (1-cycle read latency).
REQ-022 SHALL issue a read only if FIFO occupancy + in-flight reads - pop this cycle < 2; FIFO never overflows.
REQ-023 SHALL sustain 1 beat/cycle with m_ready held high; first m_valid two cycles after the start edge.
REQ-024 SHALL hold m_data/m_last stable and m_valid high while m_valid=1 and m_ready=0 (AXI-stream rules).
REQ-025 SHALL assert m_last exactly with beat length-1.
REQ-026 SHALL enter DONE on the handshake of the m_last beat; done high for exactly the DONE cycle; busy high in RUN only.
REQ-027 SHALL drive bram_enb=0 whenever no read is issued; bram_addrb holds last value.
REQ-028 SHALL never issue more than length reads per transfer.

Reset
REQ-029 SHALL, on reset_n low (any time, including mid-transfer), asynchronously force: FSM IDLE, busy=0, done=0, bram_enb=0, bram_addrb=0, m_valid=0, m_last=0, m_data=0, FIFO empty, counters 0.
REQ-030 SHALL not pulse done for a transfer aborted by reset; first start after reset_n release is served normally.

Structure
REQ-031 SHALL take UB_DATA_WIDTH=128, UB_DEPTH=256, UB_ADDR_WIDTH=8 and the FSM state encoding from shared package tpu_pkg.
REQ-032 SHALL instantiate one sub-module ub_rd_fifo2 (2-entry, registered outputs, push/pop/count).

Verification
REQ-033 SHALL cover: base=0x10, length=4, m_ready=1 -> addrb 0x10..0x13 on consecutive cycles, 4 beats back-to-back, m_last on beat 3, done 1 cycle after beat 3.
REQ-034 SHALL cover: base=0xFE, length=4 -> addresses 0xFE,0xFF,0x00,0x01 in order.
REQ-035 SHALL cover: length=8, m_ready toggling 1,0,0,1 repeating -> 8 beats in order, no loss/duplication, m_data stable while stalled, bram_enb never leaves >2 rows buffered.
REQ-036 SHALL cover: length=0 -> no bram_enb, no m_valid, done 1 cycle after start; length=256 -> 256 beats covering all addresses.
REQ-037 SHALL cover: reset_n low after beat 2 of length=6 -> all outputs 0 immediately, no done; new start base=0x20,length=2 -> 2 correct beats.
REQ-038 SHALL cover: start pulsed while busy -> ignored, current transfer completes unchanged.

Source files
------------

// File: rtl/tpu_pkg.sv
// rtl/tpu_pkg.sv - shared unified-buffer geometry and reader FSM encoding
package tpu_pkg;

  // Unified buffer: 256 rows of 16 lanes x 8 bits.
  localparam int UB_DATA_WIDTH = 128;
  localparam int UB_DEPTH      = 256;
  localparam int UB_ADDR_WIDTH = 8;

  // Stream reader FSM encoding.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/ub_rd_fifo2.sv
// rtl/ub_rd_fifo2.sv - 2-entry shift FIFO with registered head output
//
// Ports:
//   clk, reset_n     clock, asynchronous active-low reset
//   push, din        write strobe and data
//   pop              consume head (ignored when empty)
//   dout, valid      head entry and non-empty flag
//   count            current occupancy 0..2
module ub_rd_fifo2
  import tpu_pkg::*;
#(
  parameter int WIDTH = UB_DATA_WIDTH + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] slot0_q, slot0_d;
  logic [WIDTH-1:0] slot1_q, slot1_d;
  logic [1:0]       count_q, count_d;
  logic             do_pop;
  logic             do_push;
  logic [1:0]       wr_idx;

  assign do_pop  = pop && (count_q != 2'd0);
  assign do_push = push && ((count_q != 2'd2) || do_pop);
  // Slot that receives the new entry once any pop has shifted the queue.
  assign wr_idx  = count_q - {1'b0, do_pop};

  always_comb begin
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
    if (do_pop) begin
      slot0_d = slot1_q;
    end
    if (do_push) begin
      if (wr_idx == 2'd0) begin
        slot0_d = din;
      end else begin
        slot1_d = din;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      slot0_q <= '0;
      slot1_q <= '0;
      count_q <= 2'd0;
    end else begin
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
      count_q <= count_d;
    end
  end

  assign dout  = slot0_q;
  assign valid = (count_q != 2'd0);
  assign count = count_q;

endmodule

// File: rtl/ub_stream_reader.sv
// rtl/ub_stream_reader.sv - streams a block of unified-buffer rows as a ready/valid beat stream
//
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   start, base_addr,       block request; address and row count sampled with start
//   length
//   busy, done              transfer in progress / one-cycle completion pulse
//   bram_enb, bram_addrb,   buffer read port, one-cycle read latency
//   bram_doutb
//   m_valid, m_ready,       output beat stream; m_last flags the final row
//   m_data, m_last
module ub_stream_reader
  import tpu_pkg::*;
#(
  parameter  int DATA_WIDTH = UB_DATA_WIDTH,
  parameter  int DEPTH      = UB_DEPTH,
  localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
  output logic                  busy,
  output logic                  done,
  output logic                  bram_enb,
  output logic [ADDR_WIDTH-1:0] bram_addrb,
  input  logic [DATA_WIDTH-1:0] bram_doutb,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last
);

  localparam int CW = ADDR_WIDTH + 1;

  logic [1:0]            state_q, state_d;
  logic [CW-1:0]         len_q, len_d;
  logic [CW-1:0]         issued_q, issued_d;
  logic                  enb_q, enb_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  last_rd_q, last_rd_d;

  logic [DATA_WIDTH:0]   fifo_dout;
  logic                  fifo_valid;
  logic [1:0]            fifo_count;
  logic                  pop;
  logic [2:0]            fill_next;
  logic [ADDR_WIDTH-1:0] addr_inc;

  assign pop = fifo_valid && m_ready;

  // Rows held after this edge: the read now completing lands in the FIFO,
  // the accepted beat leaves it. A new read may only be issued if there is
  // guaranteed room for it when it returns, independent of future m_ready.
  assign fill_next = {1'b0, fifo_count} + {2'b0, enb_q} - {2'b0, pop};

  assign addr_inc = (addr_q == ADDR_WIDTH'(DEPTH - 1)) ? '0 : addr_q + ADDR_WIDTH'(1);

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    issued_d  = issued_q;
    enb_d     = 1'b0;
    addr_d    = addr_q;
    last_rd_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (length == CW'(0)) begin
            state_d = ST_DONE;
          end else begin
            // FIFO is always empty in IDLE, so the first read goes out at once.
            state_d   = ST_RUN;
            len_d     = length;
            issued_d  = CW'(1);
            enb_d     = 1'b1;
            addr_d    = base_addr;
            last_rd_d = (length == CW'(1));
          end
        end
      end
      ST_RUN: begin
        if ((issued_q < len_q) && (fill_next < 3'd2)) begin
          enb_d     = 1'b1;
          addr_d    = addr_inc;
          issued_d  = issued_q + CW'(1);
          last_rd_d = (issued_q == len_q - CW'(1));
        end
        if (pop && fifo_dout[DATA_WIDTH]) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      len_q     <= '0;
      issued_q  <= '0;
      enb_q     <= 1'b0;
      addr_q    <= '0;
      last_rd_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      issued_q  <= issued_d;
      enb_q     <= enb_d;
      addr_q    <= addr_d;
      last_rd_q <= last_rd_d;
    end
  end

  // The last-row flag travels with the data so m_last stays aligned with its beat.
  ub_rd_fifo2 #(
    .WIDTH (DATA_WIDTH + 1)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (enb_q),
    .din     ({last_rd_q, bram_doutb}),
    .pop     (pop),
    .dout    (fifo_dout),
    .valid   (fifo_valid),
    .count   (fifo_count)
  );

  assign busy       = (state_q == ST_RUN);
  assign done       = (state_q == ST_DONE);
  assign bram_enb   = enb_q;
  assign bram_addrb = addr_q;
  assign m_valid    = fifo_valid;
  assign m_data     = fifo_dout[DATA_WIDTH-1:0];
  assign m_last     = fifo_valid && fifo_dout[DATA_WIDTH];

endmodule

// File: tb/tb_ub_stream_reader.sv
// tb/tb_ub_stream_reader.sv - scoreboard bench for ub_stream_reader
module tb_ub_stream_reader;

  localparam int DW    = 128;
  localparam int DEPTH = 256;
  localparam int AW    = 8;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   length;
  logic          busy;
  logic          done;
  logic          bram_enb;
  logic [AW-1:0] bram_addrb;
  logic [DW-1:0] bram_doutb;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          m_last;

  always #5 clk = ~clk;

  ub_stream_reader dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .base_addr  (base_addr),
    .length     (length),
    .busy       (busy),
    .done       (done),
    .bram_enb   (bram_enb),
    .bram_addrb (bram_addrb),
    .bram_doutb (bram_doutb),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_last     (m_last)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  beat_t         exp_beats[$];
  int            exp_addrs[$];
  logic [DW-1:0] mem [DEPTH];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int ready_mode = 0;
  int start_cyc  = 0;
  int addr_idx   = 0;
  int beat_idx   = 0;
  int exp_done_cyc = -10;
  int rd_issued   = 0;
  int rd_accepted = 0;
  bit in_run = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_data(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Buffer model: row data appears by the negedge of a read cycle; junk otherwise.
  initial begin
    bram_doutb = '0;
    forever begin
      @(negedge clk);
      if (bram_enb) bram_doutb = mem[bram_addrb];
      else          bram_doutb = {$urandom, $urandom, $urandom, $urandom};
    end
  end

  // Downstream ready: 0 = always, 1 = pattern 1,0,0,1, 2 = random.
  initial begin
    logic [3:0] pat;
    pat = 4'b1001;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       m_ready = 1'b1;
        1:       m_ready = pat[cyc % 4];
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor / scoreboard.
  initial begin
    bit            stall_prev;
    logic [DW-1:0] prev_data;
    logic          prev_last;
    beat_t         b;
    int            a;
    stall_prev = 1'b0;
    prev_data  = '0;
    prev_last  = 1'b0;
    forever begin
      @(negedge clk);
      if (reset_n) begin
        chk("done_timing", int'(done), int'(cyc == exp_done_cyc));
        chk("busy", int'(busy), int'(in_run));
        if (stall_prev) begin
          chk("stall_valid", int'(m_valid), 1);
          chk_data("stall_data", m_data, prev_data);
          chk("stall_last", int'(m_last), int'(prev_last));
        end
        if (bram_enb) begin
          rd_issued++;
          chk("rows_buffered_le2", int'((rd_issued - rd_accepted) <= 2), 1);
          if (exp_addrs.size() == 0) begin
            chk("unexpected_read", 1, 0);
          end else begin
            a = exp_addrs.pop_front();
            chk("bram_addrb", int'(bram_addrb), a);
            if (ready_mode == 0) chk("read_cycle", cyc, start_cyc + addr_idx);
            addr_idx++;
          end
        end
        if (m_valid && m_ready) begin
          rd_accepted++;
          if (exp_beats.size() == 0) begin
            chk("unexpected_beat", 1, 0);
          end else begin
            b = exp_beats.pop_front();
            chk_data("m_data", m_data, b.data);
            chk("m_last", int'(m_last), int'(b.last));
            if (ready_mode == 0) chk("beat_cycle", cyc, start_cyc + 1 + beat_idx);
            beat_idx++;
            if (b.last) begin
              in_run = 1'b0;
              exp_done_cyc = cyc + 1;
            end
          end
        end
        stall_prev = m_valid && !m_ready;
        prev_data  = m_data;
        prev_last  = m_last;
      end else begin
        stall_prev = 1'b0;
      end
    end
  end

  task automatic do_start(input int b, input int l, input bit model);
    @(negedge clk);
    start     = 1'b1;
    base_addr = AW'(b);
    length    = (AW + 1)'(l);
    @(posedge clk);
    #1;
    start     = 1'b0;
    base_addr = AW'($urandom);
    length    = (AW + 1)'($urandom);
    if (model) begin
      start_cyc = cyc;
      addr_idx  = 0;
      beat_idx  = 0;
      if (l == 0) begin
        exp_done_cyc = cyc;
      end else begin
        in_run = 1'b1;
        for (int k = 0; k < l; k++) begin
          int ad;
          beat_t e;
          ad = (b + k) % DEPTH;
          e.data = mem[ad];
          e.last = (k == l - 1);
          exp_addrs.push_back(ad);
          exp_beats.push_back(e);
        end
      end
    end
  endtask

  task automatic wait_done(input int budget);
    bit got;
    got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk);
      if (done) got = 1'b1;
    end
    chk("done_seen", int'(got), 1);
    @(negedge clk);
    chk("beats_left", exp_beats.size(), 0);
    chk("reads_left", exp_addrs.size(), 0);
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_enb"}, int'(bram_enb), 0);
    chk({tag, "_addrb"}, int'(bram_addrb), 0);
    chk({tag, "_m_valid"}, int'(m_valid), 0);
    chk({tag, "_m_last"}, int'(m_last), 0);
    chk_data({tag, "_m_data"}, m_data, '0);
  endtask

  initial begin
    bit got;
    reset_n   = 1'b0;
    start     = 1'b0;
    base_addr = '0;
    length    = '0;
    m_ready   = 1'b1;
    for (int i = 0; i < DEPTH; i++) mem[i] = {$urandom, $urandom, $urandom, $urandom};

    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    #2 reset_n = 1'b1;

    // Straight block, back-to-back beats.
    ready_mode = 0;
    do_start(8'h10, 4, 1);
    wait_done(20);

    // Address wrap 0xFF -> 0x00.
    do_start(8'hFE, 4, 1);
    wait_done(20);

    // Stalling downstream.
    ready_mode = 1;
    do_start(8'h40, 8, 1);
    wait_done(80);

    // Empty block.
    ready_mode = 0;
    do_start(8'h33, 0, 1);
    wait_done(5);

    // Whole buffer.
    do_start(8'h9C, 256, 1);
    wait_done(400);

    // Start while busy must be ignored.
    ready_mode = 1;
    do_start(8'h80, 8, 1);
    repeat (3) @(negedge clk);
    do_start(8'h05, 3, 0);
    wait_done(80);

    // Reset in the middle of a transfer.
    ready_mode = 0;
    do_start(8'h50, 6, 1);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      #1;
      if (beat_idx >= 2) got = 1'b1;
    end
    chk("abort_point_reached", int'(got), 1);
    reset_n = 1'b0;
    #1;
    check_outputs_zero("abort");
    exp_beats.delete();
    exp_addrs.delete();
    in_run       = 1'b0;
    exp_done_cyc = -10;
    rd_issued    = 0;
    rd_accepted  = 0;
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b1;
    repeat (4) @(negedge clk);
    do_start(8'h20, 2, 1);
    wait_done(20);

    // Random blocks.
    for (int t = 0; t < 12; t++) begin
      int l;
      ready_mode = $urandom_range(0, 2);
      l = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 20);
      do_start($urandom_range(0, DEPTH - 1), l, 1);
      wait_done(l * 8 + 20);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
